// File: rtl/mm_job_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : mm_job_sched_if
// Brief   : Host command / response handshake bundle for mm_job_sched.
// Revision: 1.0 - initial release
// ============================================================================
interface mm_job_sched_if #(
    parameter int MATRIXSIZE_W = 16,
    parameter int TAG_W        = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [MATRIXSIZE_W-1:0] cmd_m1;
    logic [MATRIXSIZE_W-1:0] cmd_m3;
    logic [TAG_W-1:0]        cmd_tag;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [TAG_W-1:0]        rsp_tag;
    logic [1:0]              rsp_status;

    modport master (
        output cmd_valid, cmd_m1, cmd_m3, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tag, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_m1, cmd_m3, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tag, rsp_status
    );
endinterface
`default_nettype wire

// File: rtl/mm_job_sched.sv
`default_nettype none
// ============================================================================
// Module  : mm_job_sched
// Brief   : Validates matrix-multiply jobs, configures the array / D read-out,
//           tracks completion and returns one tagged status per job.
//           Optional watchdog: define MM_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mm_job_sched #(
    parameter int N1             = 4,
    parameter int N2             = 4,
    parameter int MATRIXSIZE_W   = 16,
    parameter int MEM_DEPTH_D    = 4096,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    mm_job_sched_if.slave                bus,
    output logic [MATRIXSIZE_W-1:0]      cfg_M3,
    output logic [MATRIXSIZE_W-1:0]      cfg_M1dN1,
    output logic [MATRIXSIZE_W-1:0]      cfg_M1xM3dN1,
    output logic                         start_multiply,
    input  wire logic                    done_multiply,
    input  wire logic                    mon_tvalid,
    input  wire logic                    mon_tready,
    input  wire logic                    mon_tlast,
    output logic                         busy
);
    localparam int                      c_LOG2_N1 = $clog2(N1);
    localparam int                      c_PW      = 2 * MATRIXSIZE_W;
    localparam logic [MATRIXSIZE_W-1:0] c_N1_MASK = MATRIXSIZE_W'(N1 - 1);
    localparam logic [MATRIXSIZE_W-1:0] c_N2_MASK = MATRIXSIZE_W'(N2 - 1);
    localparam logic [c_PW-1:0]         c_DEPTH   = c_PW'(MEM_DEPTH_D);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT_MUL = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    logic [2:0]              r_state;
    logic [MATRIXSIZE_W-1:0] r_m1;
    logic [MATRIXSIZE_W-1:0] r_m3;
    logic [TAG_W-1:0]        r_tag;
    logic [c_PW-1:0]         r_beats;
    logic                    r_done_meta;
    logic                    r_done_s;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [TAG_W-1:0]        r_rsp_tag;
    logic [1:0]              r_rsp_status;
    logic [MATRIXSIZE_W-1:0] r_cfg_M3;
    logic [MATRIXSIZE_W-1:0] r_cfg_M1dN1;
    logic [MATRIXSIZE_W-1:0] r_cfg_M1xM3dN1;
    logic                    r_start;
    logic                    r_busy;

    logic [MATRIXSIZE_W-1:0] w_m1_div;
    logic [c_PW-1:0]         w_prod;
    logic                    w_illegal;
    logic                    w_beat;
    logic [c_PW-1:0]         w_beats_next;
    logic [c_PW-1:0]         w_expected;
    logic                    w_timeout;

    // Product is formed at double width so oversize jobs cannot wrap into range.
    assign w_m1_div     = r_m1 >> c_LOG2_N1;
    assign w_prod       = {{MATRIXSIZE_W{1'b0}}, w_m1_div} * {{MATRIXSIZE_W{1'b0}}, r_m3};
    assign w_illegal    = (r_m1 == '0) || (r_m3 == '0) ||
                          ((r_m1 & c_N1_MASK) != '0) || ((r_m3 & c_N2_MASK) != '0) ||
                          (w_prod > c_DEPTH);
    assign w_beat       = mon_tvalid & mon_tready;
    assign w_beats_next = r_beats + c_PW'(1);
    assign w_expected   = {{MATRIXSIZE_W{1'b0}}, r_cfg_M1xM3dN1} << c_LOG2_N1;

`ifdef MM_SCHED_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0] r_tcnt;

    // Held at zero outside WAIT_MUL/DRAIN, so every entry starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state == S_WAIT_MUL || r_state == S_DRAIN) begin
            r_tcnt <= r_tcnt + c_TW'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    assign w_timeout = (r_tcnt == c_TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_meta <= 1'b0;
            r_done_s    <= 1'b0;
        end else begin
            r_done_meta <= done_multiply;
            r_done_s    <= r_done_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_m1           <= '0;
            r_m3           <= '0;
            r_tag          <= '0;
            r_beats        <= '0;
            r_cmd_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_tag      <= '0;
            r_rsp_status   <= 2'b00;
            r_cfg_M3       <= '0;
            r_cfg_M1dN1    <= '0;
            r_cfg_M1xM3dN1 <= '0;
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_m1        <= bus.cmd_m1;
                        r_m3        <= bus.cmd_m3;
                        r_tag       <= bus.cmd_tag;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_tag    <= r_tag;
                        r_rsp_status <= 2'b01;
                        r_state      <= S_RESP;
                    end else begin
                        r_cfg_M3       <= r_m3;
                        r_cfg_M1dN1    <= w_m1_div;
                        r_cfg_M1xM3dN1 <= w_prod[MATRIXSIZE_W-1:0];
                        // Pulse alongside the cfg load when no stale done is pending.
                        if (!r_done_s) begin
                            r_start <= 1'b1;
                            r_state <= S_WAIT_MUL;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (!r_done_s) begin
                        r_start <= 1'b1;
                        r_state <= S_WAIT_MUL;
                    end
                end
                S_WAIT_MUL: begin
                    if (w_timeout) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_tag    <= r_tag;
                        r_rsp_status <= 2'b10;
                        r_state      <= S_RESP;
                    end else if (r_done_s) begin
                        r_beats <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_beat && mon_tlast) begin
                        r_beats      <= w_beats_next;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_tag    <= r_tag;
                        r_rsp_status <= (w_beats_next == w_expected) ? 2'b00 : 2'b11;
                        r_state      <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_tag    <= r_tag;
                        r_rsp_status <= 2'b10;
                        r_state      <= S_RESP;
                    end else if (w_beat) begin
                        r_beats <= w_beats_next;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.rsp_status = r_rsp_status;
    assign cfg_M3         = r_cfg_M3;
    assign cfg_M1dN1      = r_cfg_M1dN1;
    assign cfg_M1xM3dN1   = r_cfg_M1xM3dN1;
    assign start_multiply = r_start;
    assign busy           = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mm_job_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mm_job_sched
// Brief   : Self-checking bench for mm_job_sched: directed vector table,
//           stale-done / reset-abort sequences and randomized jobs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mm_job_sched;
    localparam int c_N1 = 4;
    localparam int c_N2 = 4;
    localparam int c_W  = 16;
    localparam int c_DEPTH = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [c_W-1:0] cfg_M3, cfg_M1dN1, cfg_M1xM3dN1;
    logic start_multiply, busy;
    logic done_multiply = 1'b0;
    logic mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
    int checks = 0;
    int errors = 0;
    int n_starts = 0;

    mm_job_sched_if #(.MATRIXSIZE_W(c_W), .TAG_W(4)) bus ();

    mm_job_sched #(
        .N1(c_N1), .N2(c_N2), .MATRIXSIZE_W(c_W), .MEM_DEPTH_D(c_DEPTH), .TAG_W(4)
`ifdef MM_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cfg_M3(cfg_M3), .cfg_M1dN1(cfg_M1dN1), .cfg_M1xM3dN1(cfg_M1xM3dN1),
        .start_multiply(start_multiply), .done_multiply(done_multiply),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start_multiply === 1'b1) n_starts++;

    typedef struct {
        int m1; int m3; int tag; int beats; int stale;
        int exp_st; int exp_d; int exp_p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: legality, derived configuration and beat count.
    function automatic void model(input int m1, input int m3, output bit legal,
                                  output int d, output int p, output int cnt);
        longint prod;
        prod  = longint'(m1 / c_N1) * longint'(m3);
        legal = (m1 != 0) && (m3 != 0) && (m1 % c_N1 == 0) && (m3 % c_N2 == 0) &&
                (prod <= c_DEPTH);
        d     = m1 / c_N1;
        p     = int'(prod);
        cnt   = int'(prod) * c_N1;
    endfunction

    task automatic issue_cmd(input int m1, input int m3, input int tag);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("cmd_ready_before_accept", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_m1    = c_W'(m1);
        bus.cmd_m3    = c_W'(m3);
        bus.cmd_tag   = 4'(tag);
        tick();
        bus.cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_after_accept", bus.cmd_ready, 0);
    endtask

    task automatic run_job(input int m1, input int m3, input int tag, input int beats,
                           input int stale, input int exp_st, input int exp_d,
                           input int exp_p, input bit gaps, input int abort_at,
                           input bit keep_done);
        logic [c_W-1:0] p_m3, p_d, p_p;
        int s0, n, sent;
        p_m3 = cfg_M3; p_d = cfg_M1dN1; p_p = cfg_M1xM3dN1;
        issue_cmd(m1, m3, tag);
        s0 = n_starts;
        tick();
        if (exp_st == 1) begin
            chk("illegal_rsp_valid", bus.rsp_valid, 1);
            chk("illegal_status", bus.rsp_status, 1);
            chk("illegal_cfg_M3_kept", cfg_M3, p_m3);
            chk("illegal_cfg_d_kept", cfg_M1dN1, p_d);
            chk("illegal_cfg_p_kept", cfg_M1xM3dN1, p_p);
            chk("illegal_no_start", start_multiply, 0);
        end else begin
            chk("cfg_M3", cfg_M3, 64'(m3));
            chk("cfg_M1dN1", cfg_M1dN1, 64'(exp_d));
            chk("cfg_M1xM3dN1", cfg_M1xM3dN1, 64'(exp_p));
            if (stale >= 0) begin
                chk("stale_start_held", start_multiply, 0);
                repeat (stale) begin tick(); chk("stale_start_held", start_multiply, 0); end
                done_multiply = 1'b0;
            end
            n = 0;
            while (start_multiply !== 1'b1 && n < 20) begin tick(); n++; end
            chk("start_seen", start_multiply, 1);
            tick();
            chk("start_one_cycle", start_multiply, 0);
            done_multiply = 1'b1;
            repeat (4) tick();
            sent = 0; n = 0;
            while (sent < beats && n < 100000) begin
                mon_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                mon_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                mon_tlast  = (sent == beats - 1);
                tick();
                n++;
                if (mon_tvalid && mon_tready) sent++;
                if (abort_at >= 0 && sent == abort_at) begin
                    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
                    #2 rst = 1'b1;
                    #1;
                    chk("abort_rsp_valid", bus.rsp_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_cmd_ready", bus.cmd_ready, 0);
                    chk("abort_cfg", {cfg_M3, cfg_M1dN1, cfg_M1xM3dN1}, 0);
                    chk("abort_start", start_multiply, 0);
                    chk("abort_rsp_fields", {bus.rsp_tag, bus.rsp_status}, 0);
                    done_multiply = 1'b0;
                    repeat (2) @(posedge clk);
                    #3 rst = 1'b0;
                    return;
                end
                if (sent < beats) chk("no_early_rsp", bus.rsp_valid, 0);
            end
            mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
            chk("drain_rsp_valid", bus.rsp_valid, 1);
            chk("drain_status", bus.rsp_status, 64'(exp_st));
        end
        chk("rsp_tag", bus.rsp_tag, 64'(tag & 15));
        tick();
        chk("rsp_held_valid", bus.rsp_valid, 1);
        chk("rsp_held_status", bus.rsp_status, 64'(exp_st));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_dropped", bus.rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("start_count", 64'(n_starts - s0), (exp_st == 1) ? 0 : 1);
        if (!keep_done) begin
            done_multiply = 1'b0;
            repeat (3) tick();
        end
    endtask

    vec_t tbl[10];

    initial begin
        bit lg; int d, p, cnt, m1, m3, bt, st;
        tbl[0] = '{8,    16,   3,  128,   -1, 0, 2, 32};
        tbl[1] = '{6,    16,   5,  0,     -1, 1, 0, 0};
        tbl[2] = '{4096, 8,    7,  0,     -1, 1, 0, 0};
        tbl[3] = '{4,    4,    9,  3,     -1, 3, 1, 4};
        tbl[4] = '{0,    4,    1,  0,     -1, 1, 0, 0};
        tbl[5] = '{4,    6,    2,  0,     -1, 1, 0, 0};
        tbl[6] = '{64,   4096, 4,  0,     -1, 1, 0, 0};
        tbl[7] = '{4,    4096, 6,  16384, -1, 0, 1, 4096};
        tbl[8] = '{8,    4,    12, 32,     3, 0, 2, 8};
        tbl[9] = '{4,    8,    15, 33,    -1, 3, 1, 8};

        bus.cmd_valid = 1'b0; bus.cmd_m1 = '0; bus.cmd_m3 = '0; bus.cmd_tag = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_start", start_multiply, 0);
        chk("reset_cfg", {cfg_M3, cfg_M1dN1, cfg_M1xM3dN1}, 0);
        chk("reset_rsp_fields", {bus.rsp_tag, bus.rsp_status}, 0);
        #2 rst = 1'b0;
        tick();
        chk("post_reset_cmd_ready", bus.cmd_ready, 1);

        // A tlast beat while idle must not produce any response.
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
        repeat (3) begin tick(); chk("idle_tlast_ignored", {bus.rsp_valid, busy}, 0); end
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].m1, tbl[i].m3, tbl[i].tag, tbl[i].beats, tbl[i].stale,
                    tbl[i].exp_st, tbl[i].exp_d, tbl[i].exp_p, 1'b0, -1,
                    (i < 9) && (tbl[i + 1].stale >= 0));
        end

        run_job(4, 4, 2, 16, -1, 0, 1, 4, 1'b0, 5, 1'b0);
        repeat (5) begin tick(); chk("aborted_no_rsp", bus.rsp_valid, 0); end
        run_job(4, 4, 11, 16, -1, 0, 1, 4, 1'b0, -1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 7))
                0:       begin m1 = $urandom_range(0, 40);        m3 = 4 * $urandom_range(1, 8); end
                1:       begin m1 = 4 * $urandom_range(1, 8);     m3 = $urandom_range(0, 40);    end
                2:       begin m1 = 4 * $urandom_range(200, 1100); m3 = 4 * $urandom_range(1, 8); end
                default: begin m1 = 4 * $urandom_range(1, 8);     m3 = 4 * $urandom_range(1, 8); end
            endcase
            model(m1, m3, lg, d, p, cnt);
            bt = cnt;
            if (lg && $urandom_range(0, 3) == 0) bt = cnt + (($urandom_range(0, 1) == 0) ? 1 : -1);
            st = !lg ? 1 : ((bt == cnt) ? 0 : 3);
            run_job(m1, m3, i, lg ? bt : 0, -1, st, d, p, 1'b1, -1, 1'b0);
        end

`ifdef MM_SCHED_TIMEOUT_EN
        begin
            int n;
            issue_cmd(4, 4, 13);
            n = 0;
            while (start_multiply !== 1'b1 && n < 20) begin tick(); n++; end
            chk("to_start_seen", start_multiply, 1);
            n = 0;
            while (bus.rsp_valid !== 1'b1 && n < 300) begin tick(); n++; end
            chk("to_latency", 64'(n), 100);
            chk("to_status", bus.rsp_status, 2);
            chk("to_tag", bus.rsp_tag, 13);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            chk("to_rsp_dropped", bus.rsp_valid, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
